// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the button/switch debounce front-ends.
package debounce_pkg;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;

  function automatic int unsigned cnt_width(input int unsigned stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debouncer_bank_if.sv
// Pin-side bundle of the debouncer bank: raw inputs and sample tick in, clean levels and pulses out.
interface debouncer_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                tick;
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                any_edge;

  modport master (
    output tick, in,
    input  out, rise, fall, any_edge
  );

  modport slave (
    input  tick, in,
    output out, rise, fall, any_edge
  );
endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, stability counter, output level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = cnt_width(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in_async,
  output logic out,
  output logic rise,
  output logic fall,
  output logic edge_d
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        out_d  = ~out_q;
        cnt_d  = '0;
        rise_d = ~out_q;
        fall_d = out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  // Next-state pulse lets the bank register any_edge on the same edge as rise/fall.
  assign edge_d = rise_d | fall_d;

endmodule

// File: rtl/debouncer_bank.sv
// Bank of independent debounce channels with a shared registered any-edge pulse.
module debouncer_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input logic             clk,
  input logic             rst,
  debouncer_bank_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);

  logic [CHANNELS-1:0] out_w, rise_w, fall_w, edge_w;
  logic                any_edge_q, any_edge_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (bus.tick),
      .in_async(bus.in[g]),
      .out     (out_w[g]),
      .rise    (rise_w[g]),
      .fall    (fall_w[g]),
      .edge_d  (edge_w[g])
    );
  end

  always_comb begin
    any_edge_d = |edge_w;
  end

  always_ff @(posedge clk) begin
    if (rst) any_edge_q <= 1'b0;
    else     any_edge_q <= any_edge_d;
  end

  assign bus.out      = out_w;
  assign bus.rise     = rise_w;
  assign bus.fall     = fall_w;
  assign bus.any_edge = any_edge_q;

endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
- Multi-channel, counter-based debouncer for the push-button and switch inputs on the board.
- Each channel synchronises an asynchronous input and qualifies it against a programmable stability window gated by a sample tick.
- Each channel outputs a clean level plus single-cycle rise and fall pulses, which drive the FSMs and counters downstream.
- Sits directly behind the top-level pins, one instance covering all buttons.

Parameters:
- CHANNELS, 4: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flop depth per channel (legal range 2..4).
- STABLE_CYCLES, 4: consecutive mismatching ticks required before the output level flips (>=1).
- CNT_W, $clog2(STABLE_CYCLES+1): counter width, derived; never overridden.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  sample enable; tie to 1 for per-clock sampling, or drive from a clock-enable divider for slow sampling.
- in  in  CHANNELS  raw asynchronous inputs, bit i is channel i.
- out  out  CHANNELS  debounced level, registered.
- rise  out  CHANNELS  one-clk pulse on the same edge that out[i] goes 0->1.
- fall  out  CHANNELS  one-clk pulse on the same edge that out[i] goes 1->0.
- any_edge  out  1  registered OR of rise|fall across all channels, coincident with those pulses.

Behaviour:
- Reset: rst is sampled only on the clk rising edge (synchronous, active-high).
  - On that edge, all synchroniser flops, counters, out, rise, fall and any_edge go to 0.
  - During rst, in and tick are ignored. Reset mid-count discards progress; a channel holding 1 drops to 0.
- Per channel i (identical, fully independent):
  - Synchroniser: shift chain of SYNC_STAGES flops clocked every clk regardless of tick. s_i is the last stage.
  - s_i == out[i]: counter cleared to 0 on that edge, every clk, independent of tick.
  - s_i != out[i] and tick=1:
    - counter < STABLE_CYCLES-1: counter increments.
    - counter == STABLE_CYCLES-1: out[i] toggles, counter clears, and rise[i] or fall[i] asserts on that edge.
  - s_i != out[i] and tick=0: counter holds.
  - rise and fall are deasserted on every edge where no toggle occurs. They are never both high on one channel.
- Latency with tick=1 held: a level change held stable on in[i] reaches out[i] at the (SYNC_STAGES + STABLE_CYCLES)th rising edge after the change. With the defaults this is the 6th edge.
- Glitch rejection: any excursion of s_i lasting fewer than STABLE_CYCLES qualifying ticks leaves out[i] unchanged. Returning to the out[i] level clears the count, so counting is never cumulative across glitches.
- STABLE_CYCLES=1: out follows s_i one edge later on each tick, still producing pulses.
- Simultaneous toggles on several channels on one edge:
  - each channel pulses its own rise/fall bit;
  - any_edge is a single 1-cycle pulse.
- Counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- Outputs are purely registered; there is no combinational path from in to any output.

Decomposition:
- Shared package debounce_pkg:
  - localparam function cnt_width(stable) returning $clog2(stable+1);
  - default constants DEF_SYNC_STAGES=2 and DEF_STABLE_CYCLES=4, reused by the button and switch front-ends.
- One sub-module, debounce_channel: synchroniser, counter, out flop and rise/fall flops for a single bit.
- debouncer_bank generates CHANNELS instances of debounce_channel and registers the OR-reduction into any_edge.

Test Plan:
- Clean step, defaults, tick=1: rst for 2 cycles, then in=4'b0001 held → out[0]=1 and rise[0]=1 exactly at the 6th edge. rise[0]=0 on the 7th edge. Other channels stay 0.
- Glitch rejection: in[1] pulses high for 3 clks, then returns low → out[1], rise[1] and any_edge stay 0 throughout. Then hold in[1] high for 4+ clks → out[1] rises 6 edges after the final rising transition.
- Slow tick: tick high once every 10 clks, in[2] 0→1 held → out[2] flips on the edge coinciding with the 4th tick after s_2 goes high. The counter holds between ticks.
- Multi-channel: in=4'b1111 then later 4'b0000 on one edge → rise=4'b1111 for one cycle, and later fall=4'b1111 for one cycle, each with a single any_edge pulse.
- Mid-operation reset: out=4'b0101 with in[3] counting at counter=2, assert rst for 1 edge → next edge out=0, rise=fall=0, any_edge=0, counters 0. After release, a held in=4'b0101 requires the full 6 edges to reappear.
